// File: rtl/ysyx_040066_mem_arbiter.sv
// Shares one memory port between instruction fetch and data requesters.
// Optional round-robin arbitration is enabled by `YSYX_040066_ARB_RR_EN.
module ysyx_040066_mem_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [63:0] i_addr,
  output logic        i_valid,
  output logic [31:0] i_rdata,
  output logic        i_error,
  input  logic        d_rd,
  input  logic        d_wr,
  input  logic [63:0] d_addr,
  input  logic [63:0] d_wdata,
  input  logic [7:0]  d_wmask,
  input  logic [2:0]  d_len,
  output logic        d_valid,
  output logic [63:0] d_rdata,
  output logic        d_error,
  output logic        m_req,
  output logic        m_wr,
  output logic [63:0] m_addr,
  output logic [63:0] m_wdata,
  output logic [7:0]  m_wmask,
  output logic [2:0]  m_len,
  input  logic        m_done,
  input  logic [63:0] m_rdata,
  input  logic        m_err
);

  typedef enum logic [1:0] {IDLE, IBUSY, DBUSY} state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t     state_reg;
  logic       lane_reg;
  logic       orphan_reg;
  logic [7:0] cnt_reg;
  logic       err_i_reg;
  logic       err_d_reg;

  logic d_req, d_bad, idle_arb, illegal, grant_d, grant_i;
  logic owner_req, live, i_done_ok, d_done_ok;
  logic unused_addr_bits;

  assign unused_addr_bits = ^i_addr[1:0];

  assign d_req    = d_rd | d_wr;
  assign d_bad    = d_rd & d_wr;
  // An error strobe is being presented this cycle; hold off arbitration so
  // the still-asserted request that earned it is not serviced twice.
  assign idle_arb = (state_reg == IDLE) && !err_i_reg && !err_d_reg;
  assign illegal  = idle_arb && d_bad;

`ifdef YSYX_040066_ARB_RR_EN
  logic last_d_reg;
  assign grant_d = idle_arb && d_req && !d_bad && (!i_req || !last_d_reg);
  assign grant_i = idle_arb && i_req && !d_bad && (!d_req || last_d_reg);
`else
  assign grant_d = idle_arb && d_req && !d_bad;
  assign grant_i = idle_arb && i_req && !d_req;
`endif

  // A same-cycle request drop counts as orphaned even before the flag lands.
  assign owner_req = (state_reg == IBUSY) ? i_req : d_req;
  assign live      = !orphan_reg && owner_req;
  assign i_done_ok = (state_reg == IBUSY) && m_done && live;
  assign d_done_ok = (state_reg == DBUSY) && m_done && live;

  always_comb begin
    i_valid = i_done_ok || err_i_reg;
    i_error = err_i_reg || (i_done_ok && m_err);
    i_rdata = 32'd0;
    if (i_done_ok) i_rdata = lane_reg ? m_rdata[63:32] : m_rdata[31:0];
    d_valid = d_done_ok || err_d_reg;
    d_error = err_d_reg || (d_done_ok && m_err);
    d_rdata = d_done_ok ? m_rdata : 64'd0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg  <= IDLE;
      lane_reg   <= 1'b0;
      orphan_reg <= 1'b0;
      cnt_reg    <= 8'd0;
      err_i_reg  <= 1'b0;
      err_d_reg  <= 1'b0;
      m_req      <= 1'b0;
      m_wr       <= 1'b0;
      m_addr     <= 64'd0;
      m_wdata    <= 64'd0;
      m_wmask    <= 8'd0;
      m_len      <= 3'd0;
`ifdef YSYX_040066_ARB_RR_EN
      last_d_reg <= 1'b0;
`endif
    end else begin
      err_i_reg <= 1'b0;
      err_d_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (illegal) begin
            err_d_reg <= 1'b1;
          end else if (grant_d) begin
            state_reg  <= DBUSY;
            m_req      <= 1'b1;
            m_wr       <= d_wr;
            m_addr     <= d_addr;
            m_wdata    <= d_wdata;
            m_wmask    <= d_wmask;
            m_len      <= d_len;
            cnt_reg    <= 8'd0;
            orphan_reg <= 1'b0;
`ifdef YSYX_040066_ARB_RR_EN
            last_d_reg <= 1'b1;
`endif
          end else if (grant_i) begin
            state_reg  <= IBUSY;
            m_req      <= 1'b1;
            m_wr       <= 1'b0;
            m_addr     <= {i_addr[63:3], 3'b000};
            m_wdata    <= 64'd0;
            m_wmask    <= 8'd0;
            m_len      <= 3'd2;
            lane_reg   <= i_addr[2];
            cnt_reg    <= 8'd0;
            orphan_reg <= 1'b0;
`ifdef YSYX_040066_ARB_RR_EN
            last_d_reg <= 1'b0;
`endif
          end
        end
        IBUSY, DBUSY: begin
          if (!owner_req) orphan_reg <= 1'b1;
          if (m_done) begin
            state_reg  <= IDLE;
            m_req      <= 1'b0;
            orphan_reg <= 1'b0;
          end else if (cnt_reg == TO_LAST) begin
            state_reg  <= IDLE;
            m_req      <= 1'b0;
            orphan_reg <= 1'b0;
            if (live && state_reg == IBUSY) err_i_reg <= 1'b1;
            if (live && state_reg == DBUSY) err_d_reg <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg + 8'd1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_040066_mem_arbiter.sv
// Directed self-checking bench for ysyx_040066_mem_arbiter (TIMEOUT=8).
module tb_ysyx_040066_mem_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        i_req;
  logic [63:0] i_addr;
  logic        i_valid;
  logic [31:0] i_rdata;
  logic        i_error;
  logic        d_rd, d_wr;
  logic [63:0] d_addr, d_wdata;
  logic [7:0]  d_wmask;
  logic [2:0]  d_len;
  logic        d_valid;
  logic [63:0] d_rdata;
  logic        d_error;
  logic        m_req, m_wr;
  logic [63:0] m_addr, m_wdata;
  logic [7:0]  m_wmask;
  logic [2:0]  m_len;
  logic        m_done;
  logic [63:0] m_rdata;
  logic        m_err;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  ysyx_040066_mem_arbiter #(.TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_valid(i_valid), .i_rdata(i_rdata), .i_error(i_error),
    .d_rd(d_rd), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata), .d_wmask(d_wmask),
    .d_len(d_len), .d_valid(d_valid), .d_rdata(d_rdata), .d_error(d_error),
    .m_req(m_req), .m_wr(m_wr), .m_addr(m_addr), .m_wdata(m_wdata), .m_wmask(m_wmask),
    .m_len(m_len), .m_done(m_done), .m_rdata(m_rdata), .m_err(m_err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; i_req = 0; i_addr = 0; d_rd = 0; d_wr = 0; d_addr = 0; d_wdata = 0;
    d_wmask = 0; d_len = 0; m_done = 0; m_rdata = 0; m_err = 0;
    step(); step();
    compared++;
    if ({m_req, m_wr, i_valid, d_valid, i_error, d_error} !== 6'b0) begin
      mismatched++;
      $display("FAIL reset_ctrl: got %b want 000000", {m_req, m_wr, i_valid, d_valid, i_error, d_error});
    end
    compared++;
    if ({m_addr, m_wdata, m_wmask, m_len, i_rdata, d_rdata} !== '0) begin
      mismatched++;
      $display("FAIL reset_data: m_addr=%h m_wdata=%h want all zero", m_addr, m_wdata);
    end
    rst = 1'b1;
    step();
    $display("tb: reset done");
  endtask

  task automatic test_fetch();
    i_req = 1; i_addr = 64'h8000_0004;
    step();  // cycle 1
    compared++;
    if ({m_req, m_wr, m_addr, m_len, m_wmask} !== {1'b1, 1'b0, 64'h8000_0000, 3'd2, 8'h00}) begin
      mismatched++;
      $display("FAIL fetch_issue: req=%b wr=%b addr=%h len=%0d want 1 0 80000000 2", m_req, m_wr, m_addr, m_len);
    end
    step(); step();  // cycle 3
    m_done = 1; m_rdata = 64'h0010_0073_0000_0013; m_err = 0;
    #1;
    compared++;
    if ({i_valid, i_error, d_valid, i_rdata} !== {3'b100, 32'h0010_0073}) begin
      mismatched++;
      $display("FAIL fetch_resp: iv=%b ie=%b dv=%b rdata=%h want 1 0 0 00100073", i_valid, i_error, d_valid, i_rdata);
    end
    step();
    m_done = 0; i_req = 0;
    #1;
    compared++;
    if ({m_req, i_valid} !== 2'b00) begin
      mismatched++;
      $display("FAIL fetch_idle: m_req=%b i_valid=%b want 0 0", m_req, i_valid);
    end
    $display("tb: fetch addr=%h rdata=%h", i_addr, i_rdata);
  endtask

  task automatic test_store();
    logic [145:0] exp_f;
    d_wr = 1; d_addr = 64'h8000_1000; d_wdata = 64'h1122_3344_5566_7788; d_wmask = 8'hF0; d_len = 3'd3;
    exp_f = {1'b1, 1'b1, 64'h8000_1000, 64'h1122_3344_5566_7788, 8'hF0, 3'd3};
    step();
    compared++;
    if ({m_req, m_wr, m_addr, m_wdata, m_wmask, m_len} !== exp_f) begin
      mismatched++;
      $display("FAIL store_issue: addr=%h wdata=%h mask=%h wr=%b want 80001000 1122334455667788 f0 1", m_addr, m_wdata, m_wmask, m_wr);
    end
    d_wdata = 64'hDEAD; d_addr = 64'h0;  // fields must stay latched
    step();
    compared++;
    if ({m_req, m_wr, m_addr, m_wdata, m_wmask, m_len} !== exp_f) begin
      mismatched++;
      $display("FAIL store_stable: addr=%h wdata=%h want 80001000 1122334455667788", m_addr, m_wdata);
    end
    step();
    m_done = 1; m_err = 0; m_rdata = 64'h0;
    #1;
    compared++;
    if ({d_valid, d_error, i_valid} !== 3'b100) begin
      mismatched++;
      $display("FAIL store_resp: dv=%b de=%b iv=%b want 100", d_valid, d_error, i_valid);
    end
    step();
    m_done = 0; d_wr = 0;
    $display("tb: store done");
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_d;
    int w;
`ifdef YSYX_040066_ARB_RR_EN
    exp_d = 4'b1010;  // index 0 first: D,I,D,I
`else
    exp_d = 4'b1111;
`endif
    i_req = 1; i_addr = 64'h200; d_rd = 1; d_addr = 64'h100; d_len = 3'd3; d_wmask = 8'hFF;
    for (int t = 0; t < 4; t++) begin
      w = 0;
      step();
      while (!m_req && w < 6) begin step(); w++; end
      compared++;
      if (m_addr !== (exp_d[3-t] ? 64'h100 : 64'h200)) begin
        mismatched++;
        $display("FAIL b2b_grant%0d: m_addr=%h m_req=%b want %h", t, m_addr, m_req, exp_d[3-t] ? 64'h100 : 64'h200);
      end
      m_done = 1; m_rdata = 64'h5;
      #1;
      compared++;
      if ({d_valid, i_valid} !== {exp_d[3-t], !exp_d[3-t]}) begin
        mismatched++;
        $display("FAIL b2b_resp%0d: dv=%b iv=%b want %b %b", t, d_valid, i_valid, exp_d[3-t], !exp_d[3-t]);
      end
      $display("tb: b2b txn %0d served %s", t, d_valid ? "D" : "I");
      step();
      m_done = 0;
    end
    i_req = 0; d_rd = 0;
    step();
  endtask

  task automatic test_orphan();
    i_req = 1; i_addr = 64'h300;
    step();  // cycle 1
    d_rd = 1; d_addr = 64'h400;
    step();  // cycle 2
    i_req = 0;
    step(); step();  // cycle 4
    m_done = 1; m_rdata = 64'h77;
    #1;
    compared++;
    if ({i_valid, d_valid} !== 2'b00) begin
      mismatched++;
      $display("FAIL orphan_suppress: iv=%b dv=%b want 00", i_valid, d_valid);
    end
    step();  // cycle 5
    m_done = 0;
    step();  // cycle 6
    compared++;
    if ({m_req, m_wr, m_addr} !== {2'b10, 64'h400}) begin
      mismatched++;
      $display("FAIL orphan_next_grant: req=%b addr=%h want 1 400", m_req, m_addr);
    end
    m_done = 1;
    #1;
    compared++;
    if (d_valid !== 1'b1) begin
      mismatched++;
      $display("FAIL orphan_d_resp: dv=%b want 1", d_valid);
    end
    step();
    m_done = 0; d_rd = 0;
    $display("tb: orphan fetch dropped, data served");
  endtask

  task automatic test_timeout();
    int hi;
    d_rd = 1; d_addr = 64'h500;
    hi = 0;
    for (int c = 1; c <= 8; c++) begin
      step();
      if (m_req === 1'b1 && d_valid === 1'b0) hi++;
    end
    compared++;
    if (hi !== 8) begin
      mismatched++;
      $display("FAIL timeout_busy: m_req high %0d cycles want 8", hi);
    end
    step();  // cycle 9
    compared++;
    if ({m_req, d_valid, d_error, i_valid, d_rdata} !== {4'b0110, 64'd0}) begin
      mismatched++;
      $display("FAIL timeout_strobe: req=%b dv=%b de=%b rdata=%h want 0 1 1 0", m_req, d_valid, d_error, d_rdata);
    end
    d_rd = 0;
    step();
    m_done = 1; m_rdata = 64'hFFFF;
    #1;
    compared++;
    if ({m_req, d_valid, i_valid} !== 3'b000) begin
      mismatched++;
      $display("FAIL late_done: req=%b dv=%b iv=%b want 000", m_req, d_valid, i_valid);
    end
    step();
    m_done = 0;
    $display("tb: timeout error strobe");
  endtask

  task automatic test_illegal();
    d_rd = 1; d_wr = 1; d_addr = 64'h900;
    step();
    compared++;
    if ({m_req, d_valid, d_error} !== 3'b011) begin
      mismatched++;
      $display("FAIL illegal_strobe: req=%b dv=%b de=%b want 011", m_req, d_valid, d_error);
    end
    d_rd = 0; d_wr = 0;
    step();
    compared++;
    if ({m_req, d_valid} !== 2'b00) begin
      mismatched++;
      $display("FAIL illegal_after: req=%b dv=%b want 00", m_req, d_valid);
    end
    $display("tb: illegal rd+wr rejected");
  endtask

  task automatic test_reset_mid();
    d_rd = 1; d_addr = 64'h600;
    step();
    compared++;
    if (m_req !== 1'b1) begin
      mismatched++;
      $display("FAIL rstmid_issue: m_req=%b want 1", m_req);
    end
    step();
    rst = 0;
    step();
    m_done = 1;
    #1;
    compared++;
    if ({m_req, d_valid, i_valid, m_addr} !== {3'b000, 64'd0}) begin
      mismatched++;
      $display("FAIL rstmid_clear: req=%b dv=%b iv=%b addr=%h want 0 0 0 0", m_req, d_valid, i_valid, m_addr);
    end
    rst = 1; m_done = 0; d_rd = 0;
    step();
    $display("tb: reset mid-transaction");
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_store();
    test_back_to_back();
    test_orphan();
    test_timeout();
    test_illegal();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/ysyx_040066_mem_arbiter.md
# ysyx_040066_mem_arbiter

Shares one downstream memory port between the CPU's instruction-fetch requester and its data (load/store) requester. It sits between the core and the memory/bus adapter and owns a single-outstanding transaction FSM. It also owns a watchdog timeout, response routing with lane selection for fetches, and suppression of responses whose requester has withdrawn.

## Interface
Parameters:
- TIMEOUT, default 255: cycles an issued transaction may wait for `m_done` before forced termination; the counter is 8 bits, range 1..255.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-low reset (rst=0 resets)
- i_req  in  1  fetch request, level, held until `i_valid` or withdrawn
- i_addr  in  64  fetch address, 4-byte aligned
- i_valid  out  1  one-cycle fetch response strobe
- i_rdata  out  32  fetched instruction
- i_error  out  1  fetch error, qualified by `i_valid`
- d_rd, d_wr  in  1 each  data read/write request, level
- d_addr  in  64  data address
- d_wdata  in  64  store data
- d_wmask  in  8  byte-enable mask
- d_len  in  3  access length code, passed through
- d_valid  out  1  one-cycle data response strobe
- d_rdata  out  64  load data
- d_error  out  1  data error, qualified by `d_valid`
- m_req  out  1  downstream request, held until `m_done`
- m_wr  out  1  1 = write
- m_addr  out  64  downstream address
- m_wdata  out  64  downstream write data
- m_wmask  out  8  downstream byte-enable mask
- m_len  out  3  downstream length code
- m_done  in  1  one-cycle completion strobe
- m_rdata  in  64  read data, valid with `m_done`
- m_err  in  1  access error, valid with `m_done`

## Operation
- States: IDLE, IBUSY, DBUSY.
- Arbitration happens only in IDLE:
  - Default: data wins over fetch.
  - With `YSYX_040066_ARB_RR_EN`: round-robin; see Configuration.
- On grant, register the winner's fields into the `m_*` holding registers and move to IBUSY or DBUSY.
- Fetch grant sets `m_wr`=0, `m_len`=3'd2, `m_wmask`=0, and `m_addr`={`i_addr`[63:3],3'b000}. Also store `i_addr`[2] as the lane bit.
- Data grant copies `d_addr`, `d_wdata`, `d_wmask`, `d_len` and sets `m_wr`=`d_wr`.
- `d_rd`=`d_wr`=1 is illegal:
  - No downstream access is issued.
  - Next cycle: `d_valid`=1, `d_error`=1.
  - State stays IDLE.
  - This check is evaluated before fetch arbitration, and no fetch is granted in that cycle.
- `m_req`=1 in IBUSY/DBUSY. All `m_*` fields are stable while `m_req`=1.
- On `m_done` in IBUSY:
  - `i_valid`=1; `i_rdata` = lane ? `m_rdata`[63:32] : `m_rdata`[31:0]; `i_error`=`m_err`.
  - Next state IDLE.
- On `m_done` in DBUSY: `d_valid`=1, `d_rdata`=`m_rdata`, `d_error`=`m_err`. Next state IDLE.
- Orphan handling:
  - If the owner's request drops while busy, set the orphan flag.
  - The transaction still completes downstream.
  - The response strobe is suppressed.
  - The orphan flag clears on return to IDLE.
- Watchdog:
  - The counter clears on grant and increments each busy cycle without `m_done`.
  - When it reaches TIMEOUT, the owner gets valid=1, error=1, rdata=0, unless orphaned.
  - `m_req` drops and the state returns to IDLE.
  - A late `m_done` arriving in IDLE is ignored.

## Timing
- Reset values: state IDLE; all outputs 0; counter 0; orphan 0; RR pointer = "fetch served last".
- Request seen in IDLE at cycle 0 gives `m_req`=1 from cycle 1.
- `m_done` at cycle k≥1 gives the response strobe combinationally in cycle k, and IDLE at k+1.
- Fastest back-to-back: a new grant at k+1 gives `m_req` at k+2. Throughput is one access per 2+latency cycles.
- Requesters must hold request and fields until their valid strobe. Fields are sampled only at grant.
- `m_done` while `m_req`=0 is ignored.
- Reset asserted mid-transaction:
  - Immediate return to IDLE; `m_req` drops next edge.
  - No response strobe is generated.
  - The downstream side must tolerate the abandoned request.
- Simultaneous requester drop and `m_done` in the same cycle: the drop wins and the strobe is suppressed.

## Configuration
- `YSYX_040066_ARB_RR_EN` defined:
  - Round-robin; the pointer records the last served requester.
  - On simultaneous requests, grant the other one.
  - The pointer updates at each grant, including a timeout-terminated grant.
- Undefined: fixed priority, data > fetch. The pointer logic is absent.

## Test plan
- Fetch-only, `i_addr`=0x80000004, memory returns `m_rdata`=0x00100073_00000013 after 3 cycles → `m_addr`=0x80000000, `m_len`=2, `i_valid` one cycle with `i_rdata`=0x00100073.
- Store `d_addr`=0x80001000, `d_wdata`=0x1122334455667788, `d_wmask`=0xF0 → `m_wr`=1 with fields stable until `m_done`; `d_valid`=1, `d_error`=0; no `i_valid`.
- `i_req`, `d_rd` held together for 4 transactions → default build: D,D,D,D (fetch starved while `d_rd` is held). With RR_EN: D,I,D,I.
- Fetch granted, `i_req` dropped at cycle 2, `m_done` at cycle 4 → no `i_valid`; a pending `d_rd` is granted at cycle 5.
- TIMEOUT=8, `m_done` never asserted → at cycle 8 after grant `d_valid`=1, `d_error`=1, `m_req` low; a late `m_done` has no effect.
- `d_rd`=`d_wr`=1, and separately rst=0 mid-DBUSY → first case: error strobe with `m_req` never asserted. Second case: all outputs 0 next cycle, no strobe.
